// File: rtl/jpeg_pkg.sv
// Shared JPEG decoder definitions.
//   rle_state_t      : state encoding for the AC run-length expander
//                      (FILL, DONE, CLEAR)
//   symbol_t         : one run/level symbol {run, level, eob} at the
//                      default field widths
//   DEFAULT_*        : default geometry and field widths of the expander
package jpeg_pkg;

    localparam int DEFAULT_MCU_SIZE      = 8;
    localparam int DEFAULT_COEF_BITWIDTH = 12;
    localparam int DEFAULT_RUN_BITWIDTH  = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DONE  = 2'd1,
        CLEAR = 2'd2
    } rle_state_t;

    typedef struct packed {
        logic [DEFAULT_RUN_BITWIDTH-1:0]         run;
        logic signed [DEFAULT_COEF_BITWIDTH-1:0] level;
        logic                                    eob;
    } symbol_t;

endpackage

// File: rtl/ac_run_length_expander.sv
// AC run-length expander: rebuilds one zigzag-ordered coefficient block
// from a stream of (run, level) symbols terminated by EOB or by filling
// the block.
//   clk, rst      : clock, synchronous active-high reset
//   i_valid/o_ready, i_run, i_level, i_eob : symbol input handshake
//   o_data        : N coefficients, element k is zigzag position k
//   o_last_idx    : highest position written with a nonzero level
//   o_err         : block overflowed (symbol pointed past the end)
//   o_valid/i_ready : completed-block output handshake
module ac_run_length_expander
    import jpeg_pkg::*;
#(
    parameter int MCU_SIZE      = DEFAULT_MCU_SIZE,
    parameter int COEF_BITWIDTH = DEFAULT_COEF_BITWIDTH,
    parameter int RUN_BITWIDTH  = DEFAULT_RUN_BITWIDTH,
    parameter int IDX_BITWIDTH  = $clog2(MCU_SIZE * MCU_SIZE)
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  i_valid,
    output logic                                                  o_ready,
    input  logic [RUN_BITWIDTH-1:0]                               i_run,
    input  logic [COEF_BITWIDTH-1:0]                              i_level,
    input  logic                                                  i_eob,
    output logic [MCU_SIZE*MCU_SIZE-1:0][COEF_BITWIDTH-1:0]       o_data,
    output logic [IDX_BITWIDTH-1:0]                               o_last_idx,
    output logic                                                  o_err,
    output logic                                                  o_valid,
    input  logic                                                  i_ready
);

    localparam int N  = MCU_SIZE * MCU_SIZE;
    // One extra bit so pos + run never wraps and pos can hold N itself.
    localparam int PW = IDX_BITWIDTH + 1;
    localparam logic [PW-1:0] N_P = PW'(N);

    rle_state_t state_reg, state_next;
    logic [PW-1:0]           pos_reg, pos_next;
    logic [IDX_BITWIDTH-1:0] last_idx_reg, last_idx_next;
    logic                    err_reg, err_next;
    logic [N-1:0][COEF_BITWIDTH-1:0] data_reg;

    logic          accept;
    logic          overflow;
    logic          write_en;
    logic          clear;
    logic [PW-1:0] target;
    logic [PW-1:0] target_inc;
    logic [N-1:0]  coef_we;

    assign accept     = i_valid && (state_reg == FILL);
    assign target     = pos_reg + PW'(i_run);
    assign target_inc = target + PW'(1);
    assign overflow   = (target >= N_P);
    assign write_en   = accept && !i_eob && !overflow;
    assign clear      = (state_reg == CLEAR);

    // One-hot write decode of the target position.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_we
            localparam logic [PW-1:0] GI = PW'(gi);
            assign coef_we[gi] = write_en && (target == GI);
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        pos_next      = pos_reg;
        last_idx_next = last_idx_reg;
        err_next      = err_reg;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    if (i_eob) begin
                        state_next = DONE;
                    end else if (overflow) begin
                        // Nothing is written; the block is closed as faulty.
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        pos_next = target_inc;
                        // Zero levels (including ZRL) never move last_idx.
                        if (i_level != '0) begin
                            last_idx_next = target[IDX_BITWIDTH-1:0];
                        end
                        if (target_inc == N_P) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                pos_next      = '0;
                last_idx_next = '0;
                err_next      = 1'b0;
                state_next    = FILL;
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FILL;
            pos_reg      <= '0;
            last_idx_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            last_idx_reg <= last_idx_next;
            err_reg      <= err_next;
        end
    end

    // Coefficients are plain registers so the whole block can be zeroed
    // in the single CLEAR cycle and presented in parallel.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst || clear) begin
                data_reg[k] <= '0;
            end else if (coef_we[k]) begin
                data_reg[k] <= i_level;
            end
        end
    end

    assign o_data     = data_reg;
    assign o_last_idx = last_idx_reg;
    assign o_err      = err_reg;
    assign o_valid    = (state_reg == DONE);
    assign o_ready    = (state_reg == FILL);

endmodule

// File: tb/tb_ac_run_length_expander.sv
// Directed self-checking bench for ac_run_length_expander (default
// parameters: 64 coefficients of 12 bits, 4-bit runs, 6-bit index).
module tb_ac_run_length_expander;
    import jpeg_pkg::*;

    localparam int N = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_valid;
    logic                  o_ready;
    logic [3:0]            i_run;
    logic [11:0]           i_level;
    logic                  i_eob;
    logic [N-1:0][11:0]    o_data;
    logic [5:0]            o_last_idx;
    logic                  o_err;
    logic                  o_valid;
    logic                  i_ready;

    int tests = 0;
    int fails = 0;
    int exp_data [N];

    ac_run_length_expander dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_run      (i_run),
        .i_level    (i_level),
        .i_eob      (i_eob),
        .o_data     (o_data),
        .o_last_idx (o_last_idx),
        .o_err      (o_err),
        .o_valid    (o_valid),
        .i_ready    (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) exp_data[k] = 0;
    endtask

    // Compares every coefficient against the bench model (sample at negedge).
    task automatic check_block(input string tag);
        for (int k = 0; k < N; k++) begin
            logic [11:0] e;
            e = 12'(exp_data[k]);
            check($sformatf("%s data[%0d]", tag, k), 32'(o_data[k]), 32'(e));
        end
    endtask

    // Presents one symbol for exactly one clock edge.
    task automatic send(input symbol_t s);
        @(negedge clk);
        i_valid = 1'b1;
        i_run   = s.run;
        i_level = s.level;
        i_eob   = s.eob;
        $display("[TB] symbol run=%0d level=%0d eob=%0d", s.run, s.level, s.eob);
        check("o_ready before symbol", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    function automatic symbol_t sym(input int run, input int level);
        symbol_t s;
        s.run   = 4'(run);
        s.level = 12'(level);
        s.eob   = 1'b0;
        return s;
    endfunction

    function automatic symbol_t eob();
        symbol_t s;
        s.run   = 4'(0);
        s.level = 12'(0);
        s.eob   = 1'b1;
        return s;
    endfunction

    // Releases a DONE block and checks the single CLEAR cycle.
    task automatic accept_block(input string tag);
        @(negedge clk);
        check({tag, " valid before release"}, 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        @(negedge clk);
        check({tag, " clear o_valid"}, 32'(o_valid), 32'd0);
        check({tag, " clear o_ready"}, 32'(o_ready), 32'd0);
        @(negedge clk);
        check({tag, " fill o_ready"}, 32'(o_ready), 32'd1);
        check({tag, " fill o_err"}, 32'(o_err), 32'd0);
        check({tag, " fill last_idx"}, 32'(o_last_idx), 32'd0);
        $display("[TB] block %s released", tag);
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_run   = '0;
        i_level = '0;
        i_eob   = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: ready immediately, empty block.
        @(negedge clk);
        check("reset o_ready", 32'(o_ready), 32'd1);
        check("reset o_valid", 32'(o_valid), 32'd0);
        check("reset o_err", 32'(o_err), 32'd0);
        check("reset last_idx", 32'(o_last_idx), 32'd0);
        clear_model();
        check_block("reset");

        // (0,+5),(2,-3),EOB, then hold i_ready low for 5 cycles.
        send(sym(0, 5));
        send(sym(2, -3));
        send(eob());
        clear_model();
        exp_data[0] = 5;
        exp_data[3] = -3;
        @(negedge clk);
        check("b1 o_valid", 32'(o_valid), 32'd1);
        check("b1 o_ready", 32'(o_ready), 32'd0);
        check("b1 last_idx", 32'(o_last_idx), 32'd3);
        check("b1 o_err", 32'(o_err), 32'd0);
        check_block("b1");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d o_valid", c), 32'(o_valid), 32'd1);
            check($sformatf("hold%0d data3", c), 32'(o_data[3]), 32'hFFD);
            check($sformatf("hold%0d data0", c), 32'(o_data[0]), 32'h005);
            check($sformatf("hold%0d last_idx", c), 32'(o_last_idx), 32'd3);
        end
        accept_block("b1");

        // EOB alone: all zero (proves the previous block was cleared).
        send(eob());
        clear_model();
        @(negedge clk);
        check("b2 o_valid next cycle", 32'(o_valid), 32'd1);
        check("b2 last_idx", 32'(o_last_idx), 32'd0);
        check("b2 o_err", 32'(o_err), 32'd0);
        check_block("b2");
        accept_block("b2");

        // 64 x (0,1), no EOB: completes on the 64th symbol.
        for (int k = 0; k < N; k++) send(sym(0, 1));
        for (int k = 0; k < N; k++) exp_data[k] = 1;
        @(negedge clk);
        check("b3 o_valid", 32'(o_valid), 32'd1);
        check("b3 o_ready", 32'(o_ready), 32'd0);
        check("b3 last_idx", 32'(o_last_idx), 32'd63);
        check("b3 o_err", 32'(o_err), 32'd0);
        check_block("b3");
        accept_block("b3");

        // ZRL x3, (14,7) -> pos 62; (1,1) overflows.
        send(sym(15, 0));
        send(sym(15, 0));
        send(sym(15, 0));
        send(sym(14, 7));
        @(negedge clk);
        check("b4 still filling", 32'(o_valid), 32'd0);
        check("b4 last_idx 62", 32'(o_last_idx), 32'd62);
        send(sym(1, 1));
        clear_model();
        exp_data[62] = 7;
        @(negedge clk);
        check("b4 o_valid", 32'(o_valid), 32'd1);
        check("b4 o_err", 32'(o_err), 32'd1);
        check("b4 last_idx", 32'(o_last_idx), 32'd62);
        check_block("b4");
        accept_block("b4");

        // Zero level does not move last_idx.
        send(sym(1, 4));
        send(sym(3, 0));
        send(eob());
        clear_model();
        exp_data[1] = 4;
        @(negedge clk);
        check("b5 o_valid", 32'(o_valid), 32'd1);
        check("b5 last_idx", 32'(o_last_idx), 32'd1);
        check_block("b5");
        accept_block("b5");

        // Reset mid-block discards the partial block.
        send(sym(0, 9));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst mid o_valid", 32'(o_valid), 32'd0);
        check("rst mid o_ready", 32'(o_ready), 32'd1);
        check("rst mid data0", 32'(o_data[0]), 32'd0);
        send(eob());
        clear_model();
        @(negedge clk);
        check("b6 o_valid", 32'(o_valid), 32'd1);
        check("b6 last_idx", 32'(o_last_idx), 32'd0);
        check("b6 o_err", 32'(o_err), 32'd0);
        check_block("b6");
        accept_block("b6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
